// File: rtl/control_sequencer.sv
// T-state control sequencer: fetch/decode/execute strobes for the bus-select encoder.
// Outputs are decoded from the registered state; DEC latches the instruction fields.
module control_sequencer #(
    parameter int REG_COUNT    = 16,
    parameter int OPCODE_W     = 5,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 run,
    input  logic [31:0]          ir,
    input  logic                 mem_ready,
    output logic [REG_COUNT-1:0] r_out,
    output logic                 pc_out,
    output logic                 zlo_out,
    output logic                 mdr_out,
    output logic                 c_out,
    output logic                 pc_in,
    output logic                 mar_in,
    output logic                 mdr_in,
    output logic                 ir_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic [REG_COUNT-1:0] r_in,
    output logic                 inc_pc,
    output logic [4:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 busy,
    output logic                 illegal,
    output logic                 mem_fault
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
    } state_t;

    typedef enum logic [1:0] {K_R, K_IMM, K_LD, K_ST} kind_t;

    state_t              state, state_nx, fetch_nx;
    kind_t               kind, kind_nx;
    logic [4:0]          aop, aop_nx;
    logic [3:0]          ra, rb, rc, ra_nx, rb_nx, rc_nx;
    logic [CW-1:0]       wcnt, wcnt_nx;
    logic                fault_nx, in_wait;
    logic [OPCODE_W-1:0] opc;
    logic                is_r, is_imm, is_ld, is_st, is_halt, is_nop, legal;
    logic                unused_ir;

    assign opc       = ir[31 -: OPCODE_W];
    assign unused_ir = ^ir[14:0];

    assign is_r    = (opc >= OPCODE_W'(3)) && (opc <= OPCODE_W'(10));
    assign is_imm  = (opc >= OPCODE_W'(12)) && (opc <= OPCODE_W'(14));
    assign is_ld   = (opc == OPCODE_W'(0));
    assign is_st   = (opc == OPCODE_W'(2));
    assign is_nop  = (opc == OPCODE_W'(26));
    assign is_halt = (opc == OPCODE_W'(27));
    assign legal   = is_r | is_imm | is_ld | is_st | is_nop | is_halt;

    function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_IDLE;
            kind      <= K_R;
            aop       <= '0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
            wcnt      <= '0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_nx;
            kind      <= kind_nx;
            aop       <= aop_nx;
            ra        <= ra_nx;
            rb        <= rb_nx;
            rc        <= rc_nx;
            wcnt      <= wcnt_nx;
            mem_fault <= fault_nx;
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        aop_nx   = aop;
        ra_nx    = ra;
        rb_nx    = rb;
        rc_nx    = rc;
        wcnt_nx  = wcnt;
        fault_nx = mem_fault;
        fetch_nx = run ? S_F0 : S_IDLE;
        in_wait  = (state == S_F2)
                || (state == S_E3 && kind == K_LD)
                || (state == S_E4 && kind == K_ST);
        case (state)
            S_IDLE: if (run) state_nx = S_F0;
            S_F0:   state_nx = S_F1;
            S_F1:   state_nx = S_F2;
            S_F3:   state_nx = S_DEC;
            S_DEC: begin
                ra_nx  = ir[26:23];
                rb_nx  = ir[22:19];
                rc_nx  = ir[18:15];
                aop_nx = 5'd3;
                unique case (1'b1)
                    is_r: begin
                        kind_nx  = K_R;
                        aop_nx   = 5'(opc);
                        state_nx = S_E0;
                    end
                    is_imm: begin
                        kind_nx  = K_IMM;
                        aop_nx   = (opc == OPCODE_W'(12)) ? 5'd3 :
                                   (opc == OPCODE_W'(13)) ? 5'd5 : 5'd6;
                        state_nx = S_E0;
                    end
                    is_ld: begin
                        kind_nx  = K_LD;
                        state_nx = S_E0;
                    end
                    is_st: begin
                        kind_nx  = K_ST;
                        state_nx = S_E0;
                    end
                    is_halt: state_nx = S_HALT;
                    default: state_nx = fetch_nx;
                endcase
            end
            S_E0: state_nx = S_E1;
            S_E1: state_nx = S_E2;
            S_E2: state_nx = (kind == K_R || kind == K_IMM) ? fetch_nx : S_E3;
            S_E3: if (kind == K_ST) state_nx = S_E4;
            S_E4: if (kind == K_LD) state_nx = fetch_nx;
            default: ;
        endcase
        // Memory wait states share one counter and one timeout path.
        if (in_wait) begin
            if (mem_ready) begin
                wcnt_nx  = '0;
                state_nx = (state == S_F2) ? S_F3 :
                           (state == S_E3) ? S_E4 : fetch_nx;
            end else if (wcnt == CW'(MEM_WAIT_MAX - 1)) begin
                wcnt_nx  = '0;
                fault_nx = 1'b1;
                state_nx = S_HALT;
            end else begin
                wcnt_nx  = wcnt + 1'b1;
            end
        end
    end

    always_comb begin
        r_out     = '0;
        pc_out    = 1'b0;
        zlo_out   = 1'b0;
        mdr_out   = 1'b0;
        c_out     = 1'b0;
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        r_in      = '0;
        inc_pc    = 1'b0;
        alu_op    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        busy      = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_F0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_F1: begin
                zlo_out = 1'b1;
                pc_in   = 1'b1;
            end
            S_F2: begin
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_F3: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_DEC: illegal = !legal;
            S_E0: begin
                r_out = onehot(rb);
                y_in  = 1'b1;
            end
            S_E1: begin
                if (kind == K_R) r_out = onehot(rc);
                else             c_out = 1'b1;
                z_in   = 1'b1;
                alu_op = aop;
            end
            S_E2: begin
                zlo_out = 1'b1;
                if (kind == K_R || kind == K_IMM) r_in = onehot(ra);
                else                              mar_in = 1'b1;
            end
            S_E3: begin
                mdr_in = 1'b1;
                if (kind == K_LD) mem_read = 1'b1;
                else              r_out = onehot(ra);
            end
            S_E4: begin
                if (kind == K_LD) begin
                    mdr_out = 1'b1;
                    r_in    = onehot(ra);
                end else begin
                    mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
